// File: rtl/median_kxk_filter.sv
// KxK rank filter (median/min/max/bypass) on a de/hsync/vsync pixel stream.
// Define MEDIAN_BORDER_BLACK_EN to output black instead of the centre pixel on borders.
module median_kxk_filter #(
    parameter int K        = 3,
    parameter int PW       = 8,
    parameter int CH       = 3,
    parameter int H_SIZE   = 1650,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 de,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [1:0]           mode,
    input  logic [CH*PW-1:0]     pixel_in,
    output logic                 de_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic [CH*PW-1:0]     pixel_out
);
    localparam int R   = (K - 1) / 2;
    localparam int NN  = K * K;
    localparam int DLY = R * H_SIZE + R + NN;
    localparam int CW  = $clog2(H_ACTIVE + 1);
    localparam int RW  = $clog2(V_ACTIVE + 1);
    localparam int AW  = $clog2(H_SIZE);
    localparam int PXW = CH * PW;
    localparam logic [CW-1:0] C_LO = CW'(R);
    localparam logic [CW-1:0] C_HI = CW'(H_ACTIVE - 1 - R);
    localparam logic [RW-1:0] R_LO = RW'(R);
    localparam logic [RW-1:0] R_HI = RW'(V_ACTIVE - 1 - R);

    if (K != 3 && K != 5) begin : g_bad_k
        $error("median_kxk_filter: K must be 3 or 5");
    end

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    state_t          state_q;
    logic            de_prev_q, vs_prev_q;
    logic [1:0]      mode_q;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            vs_rise, de_fall, border;

    assign vs_rise = vsync & ~vs_prev_q;
    assign de_fall = de_prev_q & ~de;

    // Position counters track the incoming pixel; the border flag travels with it.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (vs_rise) begin
            col_d = '0;
            row_d = '0;
        end else begin
            if (de) begin
                if (col_q != CW'(H_ACTIVE)) col_d = col_q + CW'(1);
            end else if (de_fall) begin
                col_d = '0;
            end
            if (de_fall && row_q != RW'(V_ACTIVE)) row_d = row_q + RW'(1);
        end
    end

    assign border = (state_q == WAIT_VS) || (col_q < C_LO) || (col_q > C_HI)
                    || (row_q < R_LO) || (row_q > R_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_VS;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            mode_q    <= 2'd0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            de_prev_q <= de;
            vs_prev_q <= vsync;
            col_q     <= col_d;
            row_q     <= row_d;
            if (vs_rise) mode_q <= mode;
            case (state_q)
                WAIT_VS: if (vs_rise) state_q <= ACTIVE;
                ACTIVE:  state_q <= ACTIVE;
                default: state_q <= WAIT_VS;
            endcase
        end
    end

    logic [AW-1:0]  wptr_q;
    logic [PXW-1:0] lb_mem [K-1][H_SIZE];
    logic [PXW-1:0] tap    [K];
    logic [PXW-1:0] wq     [K][K-1];
    logic [PW-1:0]  win_c  [CH][NN];
    logic [PXW-1:0] centre;
    logic [PXW-1:0] ctr_q  [NN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wptr_q <= '0;
        else if (wptr_q == AW'(H_SIZE - 1)) wptr_q <= '0;
        else wptr_q <= wptr_q + AW'(1);
    end

    // tap[j] is the stream delayed by exactly j lines (blanking included).
    always_comb begin
        tap[0] = pixel_in;
        for (int j = 1; j < K; j++) tap[j] = lb_mem[j-1][wptr_q];
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < K - 1; j++) lb_mem[j][wptr_q] <= tap[j];
        for (int j = 0; j < K; j++) begin
            wq[j][0] <= tap[j];
            for (int m = 1; m < K - 1; m++) wq[j][m] <= wq[j][m-1];
        end
        ctr_q[0] <= centre;
        for (int i = 1; i < NN; i++) ctr_q[i] <= ctr_q[i-1];
    end

    assign centre = wq[R][R-1];

    always_comb begin
        for (int j = 0; j < K; j++) begin
            for (int c = 0; c < CH; c++) win_c[c][j*K] = tap[j][c*PW +: PW];
            for (int i = 1; i < K; i++)
                for (int c = 0; c < CH; c++) win_c[c][j*K+i] = wq[j][i-1][c*PW +: PW];
        end
    end

    // Odd-even transposition: pass p swaps pairs starting at index p%2.
    for (genvar p = 0; p < NN; p++) begin : g_pass
        logic [PW-1:0] a [CH][NN];
        logic [PW-1:0] b [CH][NN];
        logic [PW-1:0] q [CH][NN];
        if (p == 0) begin : g_src
            assign a = win_c;
        end else begin : g_src
            assign a = g_pass[p-1].q;
        end
        always_comb begin
            b = a;
            for (int c = 0; c < CH; c++)
                for (int i = p % 2; i < NN - 1; i += 2)
                    if (a[c][i] > a[c][i+1]) begin
                        b[c][i]   = a[c][i+1];
                        b[c][i+1] = a[c][i];
                    end
        end
        always_ff @(posedge clk) q <= b;
    end

    logic [5:0]     sp_q [DLY];
    logic           out_de, out_hs, out_vs, out_border;
    logic [1:0]     out_mode;
    logic [PXW-1:0] sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) sp_q[i] <= '0;
        end else begin
            sp_q[0] <= {de, hsync, vsync, border, mode_q};
            for (int i = 1; i < DLY; i++) sp_q[i] <= sp_q[i-1];
        end
    end

    assign {out_de, out_hs, out_vs, out_border, out_mode} = sp_q[DLY-1];

    always_comb begin
        sel = ctr_q[NN-1];
        for (int c = 0; c < CH; c++) begin
            case (out_mode)
                2'd0:    sel[c*PW +: PW] = g_pass[NN-1].q[c][(NN-1)/2];
                2'd1:    sel[c*PW +: PW] = g_pass[NN-1].q[c][0];
                2'd2:    sel[c*PW +: PW] = g_pass[NN-1].q[c][NN-1];
                default: sel[c*PW +: PW] = ctr_q[NN-1][c*PW +: PW];
            endcase
        end
        if (out_border) begin
`ifdef MEDIAN_BORDER_BLACK_EN
            sel = '0;
`else
            sel = ctr_q[NN-1];
`endif
        end
        if (!out_de) sel = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            pixel_out <= '0;
        end else begin
            de_out    <= out_de;
            hsync_out <= out_hs;
            vsync_out <= out_vs;
            pixel_out <= sel;
        end
    end
endmodule

// File: tb/tb_median_kxk_filter.sv
// Bench for median_kxk_filter: K=3 on an 8x6 active / 16-clock line raster.
// Frame-level vector table plus per-cycle comparison against a window/sort model.
module tb_median_kxk_filter;
    localparam int HS = 16;
    localparam int HA = 8;
    localparam int VA = 6;
    localparam int VT = 9;
    localparam int L  = 27;

    logic        clk, rst, de, hsync, vsync;
    logic [1:0]  mode;
    logic [23:0] pixel_in;
    logic        de_out, hsync_out, vsync_out;
    logic [23:0] pixel_out;

    median_kxk_filter #(
        .K(3), .PW(8), .CH(3), .H_SIZE(HS), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .mode(mode),
        .pixel_in(pixel_in), .de_out(de_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .pixel_out(pixel_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic de, hs, vs;
        logic [23:0] pix;
        int fid, r, c;
    } exp_t;

    typedef struct {
        int pat;
        bit vs;
        logic [1:0] mode;
        int chg_row;
        logic [1:0] chg_mode;
        int pr, pc;
        logic [23:0] pexp;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        tbl[14];
    logic [23:0] img [VA][HA];
    int          checks, failures, fid, probe_fid, probe_r, probe_c;
    logic [23:0] probe_exp;
    bit          vs_seen, prev_vs, ab;
    logic [1:0]  mode_model;

    function automatic logic [23:0] bordered(input logic [23:0] x);
`ifdef MEDIAN_BORDER_BLACK_EN
        return 24'h0;
`else
        return x;
`endif
    endfunction

    function automatic logic [23:0] ref_pix(input int r, input int c);
        logic [23:0] res;
        int v[$];
        if (!vs_seen || r < 1 || r > VA - 2 || c < 1 || c > HA - 2) return bordered(img[r][c]);
        if (mode_model == 2'd3) return img[r][c];
        res = 24'h0;
        for (int ch = 0; ch < 3; ch++) begin
            v.delete();
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    v.push_back(int'(img[r+dr][c+dc][ch*8 +: 8]));
            v.sort();
            case (mode_model)
                2'd0:    res[ch*8 +: 8] = 8'(v[4]);
                2'd1:    res[ch*8 +: 8] = 8'(v[0]);
                default: res[ch*8 +: 8] = 8'(v[8]);
            endcase
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic d, input logic h, input logic v, input int r, input int c);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() >= L) begin
            e = exp_q.pop_front();
            check("sync", {29'b0, de_out, hsync_out, vsync_out}, {29'b0, e.de, e.hs, e.vs});
            check("pixel", {8'h0, pixel_out}, {8'h0, e.pix});
            if (e.fid == probe_fid && e.r == probe_r && e.c == probe_c)
                check("probe", {8'h0, pixel_out}, {8'h0, probe_exp});
        end
        if (v && !prev_vs) begin
            vs_seen    = 1'b1;
            mode_model = mode;
        end
        prev_vs = v;
        de = d;
        hsync = h;
        vsync = v;
        pixel_in = 24'h0;
        e.pix = 24'h0;
        if (d) begin
            pixel_in = img[r][c];
            e.pix = ref_pix(r, c);
        end
        e.de = d;
        e.hs = h;
        e.vs = v;
        e.fid = fid;
        e.r = r;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic make_img(input int pat);
        logic [7:0] b;
        for (int r = 0; r < VA; r++)
            for (int c = 0; c < HA; c++)
                case (pat)
                    0: img[r][c] = (r == 3 && c == 4) ? 24'hFFFFFF : 24'h404040;
                    1: img[r][c] = {3{8'(c * 16)}};
                    2: img[r][c] = 24'($urandom);
                    default: begin
                        for (int ch = 0; ch < 3; ch++) begin
                            case ($urandom_range(0, 9))
                                0: b = 8'h00;
                                1: b = 8'hFF;
                                default: b = 8'($urandom_range(40, 80));
                            endcase
                            img[r][c][ch*8 +: 8] = b;
                        end
                    end
                endcase
    endtask

    task automatic drive_frame(input bit with_vs, input int chg_row, input logic [1:0] chg_mode,
                               input int abort_line, output bit aborted);
        bit act;
        aborted = 1'b0;
        for (int ln = 0; ln < VT; ln++)
            for (int pos = 0; pos < HS; pos++) begin
                if (ln == abort_line && pos == 12) begin
                    aborted = 1'b1;
                    return;
                end
                if (ln - 3 == chg_row && pos == 0) mode = chg_mode;
                act = (ln >= 3) && (pos < HA);
                step(act, pos >= 10 && pos < 12, with_vs && ln == 0,
                     act ? ln - 3 : -1, act ? pos : -1);
            end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        de = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        pixel_in = 24'h0;
        #1;
        check("rst_outs", {5'b0, de_out, hsync_out, vsync_out, pixel_out}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < L; i++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 24'h0, -1, -1, -1});
        prev_vs = 1'b0;
        vs_seen = 1'b0;
        mode_model = 2'd0;
    endtask

    task automatic run_vec(input vec_t t);
        mode = t.mode;
        make_img(t.pat);
        fid++;
        probe_fid = fid;
        probe_r = t.pr;
        probe_c = t.pc;
        probe_exp = t.pexp;
        drive_frame(t.vs, t.chg_row, t.chg_mode, -1, ab);
    endtask

    initial begin
        rst = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0; mode = 2'd0; pixel_in = 24'h0;
        checks = 0; failures = 0; fid = 0; probe_fid = -1; probe_r = -1; probe_c = -1;
        probe_exp = 24'h0; vs_seen = 1'b0; prev_vs = 1'b0; mode_model = 2'd0;

        // pat: 0 impulse, 1 ramp, 2 random, 3 salt-and-pepper
        tbl[0]  = '{1, 1'b0, 2'd1, -1, 2'd0, 2, 3, bordered(24'h303030)};
        tbl[1]  = '{0, 1'b1, 2'd0, -1, 2'd0, 3, 4, 24'h404040};
        tbl[2]  = '{1, 1'b1, 2'd1, -1, 2'd0, 2, 4, 24'h303030};
        tbl[3]  = '{1, 1'b1, 2'd2, -1, 2'd0, 3, 5, 24'h606060};
        tbl[4]  = '{1, 1'b1, 2'd3, -1, 2'd0, 1, 6, 24'h606060};
        tbl[5]  = '{1, 1'b1, 2'd1, -1, 2'd0, 0, 3, bordered(24'h303030)};
        tbl[6]  = '{1, 1'b1, 2'd2, -1, 2'd0, 4, 7, bordered(24'h707070)};
        tbl[7]  = '{1, 1'b1, 2'd0,  2, 2'd2, 3, 4, 24'h404040};
        tbl[8]  = '{1, 1'b1, 2'd2, -1, 2'd0, 3, 4, 24'h505050};
        tbl[9]  = '{2, 1'b1, 2'd0, -1, 2'd0, 5, 2, 24'h0};
        tbl[10] = '{3, 1'b1, 2'd0, -1, 2'd0, -1, -1, 24'h0};
        tbl[11] = '{2, 1'b1, 2'd1, -1, 2'd0, -1, -1, 24'h0};
        tbl[12] = '{3, 1'b1, 2'd2, -1, 2'd0, -1, -1, 24'h0};
        tbl[13] = '{2, 1'b1, 2'd3, -1, 2'd0, -1, -1, 24'h0};

        @(negedge clk);
        reset_dut();
        // tbl[9] probes a row-5 border pixel of a random frame; its value is known once drawn.
        for (int i = 0; i < 14; i++) begin
            if (i == 9) begin
                mode = tbl[i].mode;
                make_img(tbl[i].pat);
                fid++;
                probe_fid = fid;
                probe_r = 5;
                probe_c = 2;
                probe_exp = bordered(img[5][2]);
                drive_frame(1'b1, -1, 2'd0, -1, ab);
            end else begin
                run_vec(tbl[i]);
            end
        end

        // Reset in the middle of an active output line.
        mode = 2'd0;
        make_img(2);
        fid++;
        probe_fid = -1;
        drive_frame(1'b1, -1, 2'd0, 7, ab);
        @(negedge clk);
        check("pre_rst_de", {31'b0, de_out}, 32'h1);
        check("pre_rst_pix", {8'h0, pixel_out}, {8'h0, exp_q[0].pix});
        reset_dut();

        make_img(3);
        fid++;
        drive_frame(1'b0, -1, 2'd0, -1, ab);
        make_img(3);
        fid++;
        drive_frame(1'b1, -1, 2'd0, -1, ab);
        make_img(2);
        mode = 2'd1;
        fid++;
        drive_frame(1'b1, -1, 2'd0, -1, ab);

        for (int i = 0; i < L + 4; i++) step(1'b0, 1'b0, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
